// File: rtl/uart_host_driver.sv
// uart_host_driver: host-side UART link to a DUT plus its reset sequencer.
// Frame: start, DataWidth data bits LSB first, optional even parity, one stop bit.
module uart_host_driver #(
  parameter int DataWidth   = 8,
  parameter int ClksPerBit  = 16,
  parameter int ResetCycles = 100,
  parameter int ParityEn    = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rst_req_i,
  output logic                 dut_reset_o,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DataWidth-1:0] tx_data_i,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_err_o
);
  localparam int CW = $clog2(ClksPerBit);
  localparam int BW = $clog2(DataWidth + 1);
  localparam int RW = $clog2(ResetCycles + 1);
  localparam logic [CW-1:0] CntLast = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] CntHalf = CW'(ClksPerBit / 2 - 1);
  localparam logic [BW-1:0] BitLast = BW'(DataWidth - 1);
  localparam logic [RW-1:0] RstLast = RW'(ResetCycles - 1);
  localparam logic Par = ParityEn != 0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t tx_state, rx_state;
  logic [RW-1:0] rst_cnt;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [BW-1:0] tx_bit, rx_bit;
  logic [DataWidth-1:0] tx_sh, rx_sh;
  logic tx_par, rx_perr, rx_s1, rx_s2, rx_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rst_cnt <= '0;
      dut_reset_o <= 1'b1;
    end else if (rst_req_i) begin
      rst_cnt <= '0;
      dut_reset_o <= 1'b1;
    end else if (dut_reset_o) begin
      rst_cnt <= rst_cnt == RstLast ? rst_cnt : rst_cnt + 1'b1;
      dut_reset_o <= rst_cnt != RstLast;
    end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_o <= 1'b1;
      tx_ready_o <= 1'b0;
    end else if (rst_req_i) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_o <= 1'b1;
      tx_ready_o <= 1'b0;
    end else if (tx_state == IDLE) begin
      tx_ready_o <= !dut_reset_o && !(tx_valid_i && tx_ready_o);
      if (tx_valid_i && tx_ready_o) begin
        tx_state <= START;
        tx_o <= 1'b0;
        tx_cnt <= '0;
        tx_sh <= tx_data_i;
        tx_par <= ^tx_data_i;
      end
    end else if (tx_cnt != CntLast) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        START: begin
          tx_state <= DATA;
          tx_bit <= '0;
          tx_o <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        DATA:
          if (tx_bit == BitLast) begin
            tx_state <= Par ? PARITY : STOP;
            tx_o <= !Par || tx_par;
          end else begin
            tx_bit <= tx_bit + 1'b1;
            tx_o <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
        PARITY: begin
          tx_state <= STOP;
          tx_o <= 1'b1;
        end
        default: begin
          tx_state <= IDLE;
          tx_ready_o <= 1'b1;
        end
      endcase
    end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) {rx_s1, rx_s2, rx_q} <= 3'b111;
    else {rx_s1, rx_s2, rx_q} <= {rx_i, rx_s1, rx_s2};
  // Start bit is checked at half a bit; later samples land one bit period apart.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_perr <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o <= '0;
      rx_err_o <= 1'b0;
    end else if (rst_req_i) begin
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_valid_o <= 1'b0;
      rx_err_o <= 1'b0;
    end else begin
      rx_err_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      case (rx_state)
        IDLE:
          if (!dut_reset_o && rx_q && !rx_s2) begin
            rx_state <= START;
            rx_cnt <= '0;
            rx_perr <= 1'b0;
          end
        START:
          if (rx_cnt != CntHalf) rx_cnt <= rx_cnt + 1'b1;
          else begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end
        default:
          if (rx_cnt != CntLast) rx_cnt <= rx_cnt + 1'b1;
          else begin
            rx_cnt <= '0;
            case (rx_state)
              DATA: begin
                rx_sh <= {rx_s2, rx_sh[DataWidth-1:1]};
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == BitLast) rx_state <= Par ? PARITY : STOP;
              end
              PARITY: begin
                rx_perr <= rx_s2 ^ (^rx_sh);
                rx_state <= STOP;
              end
              default: begin
                rx_state <= IDLE;
                if (!rx_s2 || rx_perr || (rx_valid_o && !rx_ready_i)) rx_err_o <= 1'b1;
                else begin
                  rx_valid_o <= 1'b1;
                  rx_data_o <= rx_sh;
                end
              end
            endcase
          end
      endcase
    end
endmodule
